// File: rtl/dsp_pkg.sv
// Shared types and constants for the FIR datapath and its downstream stages.
package dsp_pkg;

    localparam int FIR_ACC_W = 39;
    localparam int SAMPLE_W  = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // Counter width that stays at least one bit for a modulus of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO: dout shows the head entry whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO only lands when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/fir_requant_decim.sv
// Requantises the FIR accumulator to saturated Q15, decimates, and queues results
// behind a valid/ready port with sticky saturation and overflow flags.
module fir_requant_decim
    import dsp_pkg::*;
#(
    parameter int IN_W  = FIR_ACC_W,
    parameter int OUT_W = SAMPLE_W,
    parameter int SHIFT = 15,
    parameter int DECIM = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic signed [IN_W-1:0]  acc_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag,
    output logic                    drop_flag,
    input  logic                    clr_flags
);
    localparam int EXT_W = IN_W + 1;
    localparam int PH_W  = cnt_w(DECIM);

    localparam logic        [EXT_W-1:0] HALF    = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] POS_LIM = EXT_W'({(OUT_W-1){1'b1}});
    localparam logic signed [EXT_W-1:0] NEG_LIM = ~POS_LIM;

    logic              ena_d_reg;
    logic [PH_W-1:0]   phase_reg;
    logic              sat_flag_reg;
    logic              drop_flag_reg;

    logic [EXT_W-1:0]        biased;
    logic signed [EXT_W-1:0] shifted;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_W-1:0]        sample;

    logic             keep;
    logic             pop_req;
    logic             drop_evt;
    logic [OUT_W-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;

    // FIR output lags its ena edge by one clock, so consume on the delayed strobe.
    assign keep = ena_d_reg && (phase_reg == '0);

    // One guard bit keeps the rounding add from overflowing.
    assign biased  = {acc_in[IN_W-1], acc_in} + HALF;
    assign shifted = $signed(biased) >>> SHIFT;
    assign sat_hi  = shifted > POS_LIM;
    assign sat_lo  = shifted < NEG_LIM;

    always_comb begin
        sample = shifted[OUT_W-1:0];
        if (sat_hi) begin
            sample = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (sat_lo) begin
            sample = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    assign pop_req  = out_ready && !fifo_empty;
    assign drop_evt = keep && fifo_full && !pop_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ena_d_reg     <= 1'b0;
            phase_reg     <= '0;
            sat_flag_reg  <= 1'b0;
            drop_flag_reg <= 1'b0;
        end else begin
            ena_d_reg <= ena;
            if (ena_d_reg) begin
                phase_reg <= (phase_reg == PH_W'(DECIM - 1)) ? '0 : phase_reg + PH_W'(1);
            end
            // A new event outranks a coincident clear.
            if (keep && (sat_hi || sat_lo)) begin
                sat_flag_reg <= 1'b1;
            end else if (clr_flags) begin
                sat_flag_reg <= 1'b0;
            end
            if (drop_evt) begin
                drop_flag_reg <= 1'b1;
            end else if (clr_flags) begin
                drop_flag_reg <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (out_ready),
        .din   (sample),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : $signed(fifo_dout);
    assign sat_flag  = sat_flag_reg;
    assign drop_flag = drop_flag_reg;

endmodule

// File: tb/tb_fir_requant_decim.sv
// Bench for fir_requant_decim: DECIM=4 and DECIM=1 instances share stimulus and are
// checked each cycle against a queue model plus literal expectations.
module tb_fir_requant_decim;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b0;
    logic out_ready = 1'b0;
    logic clr_flags = 1'b0;
    logic signed [38:0] acc_in = '0;

    logic signed [15:0] od4, od1;
    logic ov4, ov1, sf4, sf1, df4, df1;

    int n_cmp = 0;
    int n_bad = 0;

    initial forever #5 clk = ~clk;

    fir_requant_decim #(.IN_W(39), .OUT_W(16), .SHIFT(15), .DECIM(4), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .ena(ena), .acc_in(acc_in),
        .out_data(od4), .out_valid(ov4), .out_ready(out_ready),
        .sat_flag(sf4), .drop_flag(df4), .clr_flags(clr_flags)
    );

    fir_requant_decim #(.IN_W(39), .OUT_W(16), .SHIFT(15), .DECIM(1), .DEPTH(4)) u_d1 (
        .clk(clk), .rst(rst), .ena(ena), .acc_in(acc_in),
        .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .sat_flag(sf1), .drop_flag(df1), .clr_flags(clr_flags)
    );

    // Behavioural reference: round-half-up divide by 2^15, clamp, queue of depth 4.
    function automatic longint round_q15(input longint a);
        return (a + 64'sd16384) >>> 15;
    endfunction

    function automatic int clamp16(input longint r);
        if (r > 32767)  return 32767;
        if (r < -32768) return -32768;
        return int'(r);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    bit m_ed;
    int m_ph4;
    int q4[$];
    int q1[$];
    bit m_sat4, m_drop4, m_sat1, m_drop1;

    initial forever begin
        bit     pop4, pop1, s;
        longint r;
        int     v;
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_ed = 0; m_ph4 = 0;
            q4.delete(); q1.delete();
            m_sat4 = 0; m_drop4 = 0; m_sat1 = 0; m_drop1 = 0;
        end else begin
            pop4 = (q4.size() != 0) && out_ready;
            pop1 = (q1.size() != 0) && out_ready;
            if (clr_flags) begin
                m_sat4 = 0; m_drop4 = 0; m_sat1 = 0; m_drop1 = 0;
            end
            if (pop4) void'(q4.pop_front());
            if (pop1) void'(q1.pop_front());
            if (m_ed) begin
                r = round_q15(longint'(acc_in));
                v = clamp16(r);
                s = (r > 32767) || (r < -32768);
                if (s) m_sat1 = 1;
                if (q1.size() < 4) q1.push_back(v); else m_drop1 = 1;
                if (m_ph4 == 0) begin
                    if (s) m_sat4 = 1;
                    if (q4.size() < 4) q4.push_back(v); else m_drop4 = 1;
                end
                m_ph4 = (m_ph4 + 1) % 4;
            end
            m_ed = ena;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        @(negedge clk);
        forever begin
            check("d4_valid", int'(ov4), int'(q4.size() != 0));
            check("d4_data",  int'(od4), (q4.size() != 0) ? q4[0] : 0);
            check("d4_sat",   int'(sf4), int'(m_sat4));
            check("d4_drop",  int'(df4), int'(m_drop4));
            check("d1_valid", int'(ov1), int'(q1.size() != 0));
            check("d1_data",  int'(od1), (q1.size() != 0) ? q1[0] : 0);
            check("d1_sat",   int'(sf1), int'(m_sat1));
            check("d1_drop",  int'(df1), int'(m_drop1));
            if (ov4 && out_ready) $display("xfer decim4 data=%0d", od4);
            if (ov1 && out_ready) $display("xfer decim1 data=%0d", od1);
            @(negedge clk);
        end
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic pulse(input longint val);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        acc_in = 39'(val);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic feed(input int first, input int n);
        for (int i = 0; i <= n; i++) begin
            ena = (i < n);
            acc_in = (i == 0) ? '0 : 39'(longint'(first + i - 1) * 32768);
            @(negedge clk);
        end
    endtask

    int got[$];

    task automatic drain1(input int cycles);
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            if (ov1) got.push_back(int'(od1));
            @(negedge clk);
        end
    endtask

    longint round_in[4]  = '{98304, 16384, -16384, -16385};
    int     round_exp[4] = '{3, 1, 0, -1};

    initial begin
        // Reset held with random activity on the inputs.
        for (int i = 0; i < 6; i++) begin
            ena = 1'($urandom_range(0, 1));
            acc_in = 39'({$urandom(), $urandom()});
            @(negedge clk);
        end
        check("rst_valid", int'(ov1 | ov4), 0);
        check("rst_data",  int'(od1), 0);
        check("rst_flags", int'({sf1, df1, sf4, df4}), 0);
        ena = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", int'(ov1 | ov4), 0);

        // Rounding on the pass-through instance, two edges from ena to output.
        for (int i = 0; i < 4; i++) begin
            ena = 1'b1;
            @(negedge clk);
            check("round_lat", int'(ov1), 0);
            ena = 1'b0;
            acc_in = 39'(round_in[i]);
            @(negedge clk);
            check("round_valid", int'(ov1), 1);
            check("round_val", int'(od1), round_exp[i]);
        end

        // Saturation both ways, then clear.
        pulse(longint'(1) <<< 35);
        check("sat_pos", int'(od1), 32767);
        check("sat_flag_set", int'(sf1), 1);
        pulse(-(longint'(1) <<< 36));
        check("sat_neg", int'(od1), -32768);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("sat_flag_clr", int'(sf1), 0);

        // Decimation by 4 of k*32768, k=0..11.
        reset_pulse();
        got.delete();
        for (int i = 0; i <= 16; i++) begin
            ena = (i < 12);
            acc_in = (i == 0 || i > 12) ? '0 : 39'(longint'(i - 1) * 32768);
            @(negedge clk);
            if (ov4) got.push_back(int'(od4));
        end
        check("decim_count", got.size(), 3);
        if (got.size() == 3) begin
            check("decim_0", got[0], 0);
            check("decim_1", got[1], 4);
            check("decim_2", got[2], 8);
        end

        // Backpressure: six samples into a four-entry queue.
        reset_pulse();
        out_ready = 1'b0;
        feed(1, 6);
        @(negedge clk);
        check("bp_valid", int'(ov1), 1);
        check("bp_head", int'(od1), 1);
        check("bp_drop", int'(df1), 1);
        drain1(8);
        check("bp_drain_n", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check("bp_order", got[i], i + 1);
        check("bp_empty", int'(ov1), 0);

        // Push and pop on the same edge while full keeps four entries, no drop.
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        out_ready = 1'b0;
        feed(11, 4);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        acc_in = 39'(longint'(15) * 32768);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("simul_no_drop", int'(df1), 0);
        drain1(8);
        check("simul_n", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check("simul_order", got[i], i + 12);

        // Reset mid-burst with entries queued.
        reset_pulse();
        out_ready = 1'b0;
        feed(21, 3);
        check("burst_valid", int'(ov1), 1);
        #2 rst = 1'b0;
        #1;
        check("async_valid", int'(ov1 | ov4), 0);
        check("async_data", int'(od1), 0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        pulse(longint'(5) * 32768);
        check("phase_restart_valid", int'(ov4), 1);
        check("phase_restart_data", int'(od4), 5);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_requant_decim.md
# fir_requant_decim

Downstream stage of the 74-tap FIR. Consumes the FIR's 39-bit signed combinational accumulator, rounds and arithmetically shifts it back to Q15, saturates to 16 bits and decimates by a fixed factor. Buffers results in a small FIFO behind a valid/ready output port, for the DAC/serializer stage or a bus-side reader.

## Interface
Parameters:
- IN_W, 39, accumulator width from the FIR.
- OUT_W, 16, output sample width, signed.
- SHIFT, 15, right-shift applied after rounding (Q15 coefficient scaling); legal range 1..IN_W-OUT_W.
- DECIM, 4, decimation factor; legal range 1..16. DECIM=1 passes every sample.
- DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ena  in  1  sample strobe; the same signal that drives the FIR's ena.
- acc_in  in  IN_W  signed FIR accumulator (FIR out).
- out_data  out  OUT_W  signed head-of-FIFO sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready at a rising edge.
- sat_flag  out  1  sticky; set when any kept sample saturated.
- drop_flag  out  1  sticky; set when a kept sample was discarded because the FIFO was full.
- clr_flags  in  1  synchronous clear of both sticky flags.

## Operation
- **Alignment.** The FIR's out reflects its shift register one cycle after an edge with ena=1. The block registers ena into ena_d. acc_in is consumed only at an edge where ena_d=1.
- **Decimation.** Phase counter 0..DECIM-1 advances on each consumed edge and wraps DECIM-1 to 0. A sample is kept only when phase==0 before the increment. The first sample after reset is therefore kept.
- **Rounding.** Sign-extend acc_in to IN_W+1 bits, add 2^(SHIFT-1), then arithmetic shift right by SHIFT. This is round-half-up, toward +inf on ties.
- **Saturation.** If the shifted value is above 2^(OUT_W-1)-1, output 32767. If it is below -2^(OUT_W-1), output -32768. In either case set sat_flag. Otherwise truncate to OUT_W bits.
- **FIFO push.** A kept sample is pushed at the consume edge.
- **FIFO pop.** A pop occurs at an edge with out_valid && out_ready.
- **Simultaneous push and pop when full.** Both succeed; occupancy is unchanged.
- **Push when full without a pop.** The new sample is discarded and drop_flag is set. FIFO contents and pointers are unchanged.
- **Pop when empty.** Ignored.
- **Pointer wrap.** Pointers wrap modulo DEPTH. An extra occupancy bit or counter distinguishes full from empty.
- **out_data.** Equals the head entry while out_valid=1, and 0 while out_valid=0.
- **Flag priority.** If clr_flags coincides with a new saturation or drop event, the set wins.
- **Reset.** Assertion at any time, including mid-burst, immediately returns the block to its reset state. All queued samples are lost and the phase returns to 0.

## Timing
- Reset values: out_valid=0, out_data=0, sat_flag=0, drop_flag=0, ena_d=0, phase=0, FIFO empty.
- Latency:
  - Edge E0: ena=1; the FIR shifts and ena_d is set.
  - Edge E1: acc_in is consumed and pushed.
  - out_valid=1 in the cycle after E1 if the FIFO was empty.
  - So latency is 2 edges from the ena edge to visible output.
- Throughput: one push per clock is sustainable when ena is high continuously. The FIFO pops at most one entry per clock.
- sat_flag and drop_flag update at the consume edge and are visible in the cycle after it.
- out_valid, once high, stays high until the last entry is popped. It is never withdrawn without a pop, except by reset.

## Structure
- Package dsp_pkg holds:
  - FIR_ACC_W=39 and SAMPLE_W=16;
  - the type typedef logic signed [SAMPLE_W-1:0] sample_t;
  - the constants SAMPLE_MAX and SAMPLE_MIN.
  The FIR and this block both import it.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH). It takes push/pop/din and produces dout/empty/full, with a registered memory and pointers. The same asynchronous active-low reset is applied.
- Rounding, saturation and the phase counter are local logic in fir_requant_decim.

## Test plan
All scenarios use the default parameters.
1. **Reset behaviour.** Hold rst=0 with random ena/acc_in -> out_valid=0, out_data=0 and both flags 0. Release rst -> no output until an ena pulse occurs.
2. **Rounding.** Use DECIM=1 and out_ready=1.
   - acc_in=98304 -> 3
   - acc_in=16384 -> 1
   - acc_in=-16384 -> 0
   - acc_in=-16385 -> -1

   Each output appears 2 edges after its ena edge.
3. **Saturation.** acc_in=2^35 -> 32767 with sat_flag=1. Then acc_in=-2^36 -> -32768. Then pulse clr_flags -> sat_flag=0.
4. **Decimation.** Use ena every cycle with acc_in=k*32768 for k=0..11 -> the outputs are exactly 0, 4, 8.
5. **Backpressure.** Use out_ready=0 and DECIM=1 with 6 samples -> 4 queued and drop_flag=1. Raise out_ready -> samples 1–4 are popped in order, then out_valid=0. Also check that push and pop at the same edge when full keeps occupancy at 4.
6. **Mid-burst reset.** Assert rst with 3 entries queued -> out_valid drops to 0 immediately (asynchronously). After release, the first kept sample is the first post-reset ena sample (phase restarted).
